// File: rtl/press_classifier.sv
// Classifies debounced switch activity into short, long and double-click pulses.
// Also keeps a free-running count of rising edges on the switch.
module press_classifier #(
    parameter int LONG_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 6250000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clean_switch,
    output logic       o_short_pulse,
    output logic       o_long_pulse,
    output logic       o_double_pulse,
    output logic [7:0] o_press_count
);

    // state          | meaning
    // IDLE           | waiting for a first press
    // PRESSED        | first press held, timing towards a long press
    // LONG_HELD      | long press already reported, waiting for release
    // WAIT_GAP       | first press released, timing the double-click window
    // SECOND_PRESSED | second press of a double click, waiting for release
    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        SECOND_PRESSED
    } state_t;

    localparam logic [24:0] LONG_TC = 25'(LONG_CYCLES - 1);
    localparam logic [24:0] GAP_TC  = 25'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [24:0] r_timer;
    logic        r_prev;
    logic        r_short;
    logic        r_long;
    logic        r_double;
    logic [7:0]  r_count;

    logic w_rise;
    logic w_fall;

    assign w_rise = i_clean_switch & ~r_prev;
    assign w_fall = ~i_clean_switch & r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            // Loading the live level keeps a switch held through reset from looking like a press
            r_prev   <= i_clean_switch;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_count  <= '0;
        end else begin
            r_prev   <= i_clean_switch;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            if (w_rise) begin
                r_count <= r_count + 8'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PRESSED;
                        r_timer <= '0;
                    end
                end
                PRESSED: begin
                    // Release wins over the long-press terminal count
                    if (w_fall) begin
                        r_state <= WAIT_GAP;
                        r_timer <= '0;
                    end else if (r_timer == LONG_TC) begin
                        r_state <= LONG_HELD;
                        r_long  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 25'd1;
                    end
                end
                LONG_HELD: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                    end
                end
                WAIT_GAP: begin
                    // A second press wins over the gap terminal count
                    if (w_rise) begin
                        r_state <= SECOND_PRESSED;
                    end else if (r_timer == GAP_TC) begin
                        r_state <= IDLE;
                        r_short <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 25'd1;
                    end
                end
                SECOND_PRESSED: begin
                    if (w_fall) begin
                        r_state  <= IDLE;
                        r_double <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign o_short_pulse  = r_short;
    assign o_long_pulse   = r_long;
    assign o_double_pulse = r_double;
    assign o_press_count  = r_count;

endmodule
